// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {IDLE, SERVE} state_t;

  localparam int DEF_AW   = 8;
  localparam int DEF_DW   = 8;
  localparam int MAX_NREQ = 8;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod NREQ.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Distance from ptr is computed by explicit compare so non-power-of-2 NREQ wraps correctly.
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    p      = 32'(ptr);
    best   = NREQ;
    d      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      d = (i >= p) ? (i - p) : (i + NREQ - p);
      if (req[i] && (d < best)) begin
        best      = d;
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 1W/1R data memory between NREQ requesters.
// Optional burst locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic [AW-1:0]      mem_write_addr,
  output logic [DW-1:0]      mem_write_data,
  output logic [AW-1:0]      mem_read_addr,
  input  logic [DW-1:0]      mem_read_data
);

  localparam int IW = idx_w(NREQ);

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_q, pick_oh, win_oh;
  logic [IW-1:0]   rr_ptr, pick_idx;
  logic            pick_any, win_any, lock_hold;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef DMEM_ARB_LOCK_EN
  localparam int LCW = idx_w(MAX_LOCK);
  logic [LCW-1:0] lock_cnt;

  // lock_cnt counts regrants, so MAX_LOCK total grants means MAX_LOCK-1 regrants.
  always_comb
    lock_hold = (|(gnt_q & req & req_lock)) && (32'(lock_cnt) < MAX_LOCK - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lock_cnt <= '0;
    else if (lock_hold) lock_cnt <= lock_cnt + 1'b1;
    else                lock_cnt <= '0;
  end
`else
  logic unused_lock;
  always_comb unused_lock = ^{req_lock, MAX_LOCK != 0};
  always_comb lock_hold   = 1'b0;
`endif

  // A locked regrant leaves rr_ptr alone; it already points past the holder.
  always_comb begin
    win_oh  = lock_hold ? gnt_q : pick_oh;
    win_any = lock_hold | pick_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = SERVE;
      SERVE:   if (!(|req)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      gnt_q <= win_any ? win_oh : '0;
      if (pick_any && !lock_hold)
        rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_comb begin
    gnt            = (state == SERVE) ? gnt_q : '0;
    mem_en         = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_read_addr  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_en         = req_we[i];
        mem_write_addr = req_addr[i*AW +: AW];
        mem_read_addr  = req_addr[i*AW +: AW];
        mem_write_data = req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else if ((|gnt) && !mem_en) begin
      rvalid <= gnt;
      rdata  <= mem_read_data;
    end else begin
      rvalid <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int NREQ     = 2;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_LOCK = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]    req, req_we, req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata, mem_write_data, mem_read_data;
  logic               mem_en;
  logic [AW-1:0]      mem_write_addr, mem_read_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_lock       (req_lock),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .mem_en         (mem_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data)
  );

  // Attached data memory: sync write, async read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (mem_en) mem[mem_write_addr] <= mem_write_data;
  assign mem_read_data = mem[mem_read_addr];

  // Per-requester stimulus, packed onto the flattened ports.
  logic          r_req [NREQ];
  logic          r_we  [NREQ];
  logic          r_lock[NREQ];
  logic [AW-1:0] r_addr[NREQ];
  logic [DW-1:0] r_wdata[NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i]                = r_req[i];
      req_we[i]             = r_we[i];
      req_lock[i]           = r_lock[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  end

  // Reference model state
  logic [DW-1:0]   ref_mem [256];
  int              exp_g, next_pri, run;
  logic [NREQ-1:0] exp_rvalid;
  logic [DW-1:0]   exp_rdata;
  int              n_assert = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_next();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (next_pri + k) % NREQ;
      if (r_req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_g      = -1;
    next_pri   = 0;
    run        = 0;
    exp_rvalid = '0;
    exp_rdata  = '0;
  endtask

  // Applies the effect of one rising edge using the inputs held across it.
  task automatic model_edge();
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_rvalid = '0;
    if (exp_g >= 0) begin
      if (r_we[exp_g]) ref_mem[r_addr[exp_g]] = r_wdata[exp_g];
      else begin
        exp_rdata  = ref_mem[r_addr[exp_g]];
        exp_rvalid = NREQ'(1) << exp_g;
      end
    end
    g = -1;
`ifdef DMEM_ARB_LOCK_EN
    if (exp_g >= 0 && r_req[exp_g] && r_lock[exp_g] && run < MAX_LOCK) begin
      g = exp_g;
      run++;
    end
`endif
    if (g < 0) begin
      g   = pick_next();
      run = (g >= 0) ? 1 : 0;
    end
    if (g >= 0) next_pri = (g + 1) % NREQ;
    exp_g = g;
  endtask

  task automatic check_all();
    logic [NREQ-1:0] eg;
    eg = (exp_g >= 0) ? (NREQ'(1) << exp_g) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("rvalid", 32'(rvalid), 32'(exp_rvalid));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    if (exp_g >= 0) begin
      check("mem_en", 32'(mem_en), 32'(r_we[exp_g]));
      check("mem_write_addr", 32'(mem_write_addr), 32'(r_addr[exp_g]));
      check("mem_read_addr", 32'(mem_read_addr), 32'(r_addr[exp_g]));
      check("mem_write_data", 32'(mem_write_data), 32'(r_wdata[exp_g]));
    end else begin
      check("mem_en_idle", 32'(mem_en), 32'd0);
      check("mem_addr_idle", 32'({mem_write_addr, mem_read_addr}), 32'd0);
      check("mem_wdata_idle", 32'(mem_write_data), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drop_all();
    for (int i = 0; i < NREQ; i++) begin
      r_req[i]  = 1'b0;
      r_lock[i] = 1'b0;
    end
  endtask

  // Protocol-respecting random traffic: attributes change only outside a requester's grant cycle.
  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      r_lock[i] = 1'($urandom_range(1, 0));
      if (exp_g == i) begin
        r_req[i] = 1'($urandom_range(1, 0));
      end else if (r_req[i]) begin
        if ($urandom_range(9, 0) == 0) r_req[i] = 1'b0;
      end else if ($urandom_range(1, 0) == 1) begin
        r_req[i]   = 1'b1;
        r_we[i]    = 1'($urandom_range(1, 0));
        r_addr[i]  = AW'($urandom_range(7, 0));
        r_wdata[i] = DW'($urandom);
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] seq6 [6];
    for (int a = 0; a < 256; a++) begin
      mem[a]     = '0;
      ref_mem[a] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      r_req[i]   = 1'b1;
      r_we[i]    = 1'b0;
      r_lock[i]  = 1'b0;
      r_addr[i]  = AW'(i);
      r_wdata[i] = '0;
    end
    rst_n = 1'b1;
    model_reset();

    // Reset held with both requesting
    #1 rst_n = 1'b0;
    #1 check_all();
    repeat (3) tick();

    // Contention from reset: fair alternation
    rst_n = 1'b1;
    tick(); check("t3_gnt0", 32'(gnt), 32'h1);
    tick(); check("t3_gnt1", 32'(gnt), 32'h2);
    tick(); check("t3_gnt2", 32'(gnt), 32'h1);
    tick(); check("t3_gnt3", 32'(gnt), 32'h2);
    drop_all();
    tick();
    tick();

    // Single write then read back
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 8'h05; r_wdata[0] = 8'hA5;
    tick(); check("t2_wr_gnt", 32'(gnt), 32'h1); check("t2_mem_en", 32'(mem_en), 32'h1);
    r_req[0] = 1'b0;
    tick();
    r_req[0] = 1'b1; r_we[0] = 1'b0;
    tick(); check("t2_rd_gnt", 32'(gnt), 32'h1);
    r_req[0] = 1'b0;
    tick(); check("t2_rvalid", 32'(rvalid), 32'h1); check("t2_rdata", 32'(rdata), 32'hA5);

    // Withdrawn request from requester 1 (it would otherwise win on rotation)
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 8'h05;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 8'h06;
    #2 r_req[1] = 1'b0;
    tick(); check("t5_gnt", 32'(gnt), 32'h1);
    r_req[0] = 1'b0;
    tick(); check("t5_rvalid", 32'(rvalid), 32'h1);
    tick(); check("t5_idle", 32'(gnt | rvalid), 32'h0);

    // Reset during a write's grant cycle
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 8'h10; r_wdata[0] = 8'hFF;
    tick(); check("t4_gnt", 32'(gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("t4_mem_en_async", 32'(mem_en), 32'h0); check("t4_gnt_async", 32'(gnt), 32'h0);
    model_reset();
    r_we[0] = 1'b0; r_req[0] = 1'b1; r_req[1] = 1'b1; r_addr[1] = 8'h10; r_we[1] = 1'b0;
    tick(); check("t4_mem_kept", 32'(mem[8'h10]), 32'(ref_mem[8'h10]));
    rst_n = 1'b1;
    tick(); check("t4_ptr_reset", 32'(gnt), 32'h1);
    drop_all();
    tick();
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Burst lock on requester 0 capped at MAX_LOCK grants
    seq6 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    r_req[0] = 1'b1; r_req[1] = 1'b1; r_we[0] = 1'b0; r_we[1] = 1'b0; r_lock[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6_gnt%0d", k), 32'(gnt), 32'(seq6[k]));
    end
    drop_all();
    tick();
    tick();
`else
    seq6 = '{default: '0};
`endif

    // Random traffic (req_lock toggled too; it must only matter with locking enabled)
    for (int c = 0; c < 400; c++) begin
      drive_random();
      tick();
    end
    drop_all();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
